// File: rtl/c_frag_cfg_loader_pkg.sv
// Shared types and constants for the C_FRAG serial configuration loader.
package c_frag_cfg_loader_pkg;

  localparam int unsigned FRAME_BITS = 15;
  localparam int unsigned CFG_BITS   = 14;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned BIT_PARITY = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  // Committed C_FRAG inputs; field order mirrors frame bits 13 down to 0.
  typedef struct packed {
    logic mode_split;
    logic bb2;
    logic bb1;
    logic ba2;
    logic ba1;
    logic bsl;
    logic bab;
    logic tb2;
    logic tb1;
    logic ta2;
    logic ta1;
    logic tsl;
    logic tab;
    logic tbs;
  } cfg_t;

  // Frame is good when the XOR of all frame bits equals the selected polarity.
  function automatic logic parity_pass(input logic parity, input logic odd);
    return parity == odd;
  endfunction

endpackage

// File: rtl/c_frag_cfg_loader_shift_reg.sv
// Indexed-load frame register with a running parity over every loaded bit.
// The topmost frame bit is the check bit: it only contributes to parity.
module c_frag_cfg_loader_shift_reg
  import c_frag_cfg_loader_pkg::*;
#(
  parameter int unsigned W  = FRAME_BITS,
  parameter int unsigned IW = CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load,
  input  logic [IW-1:0] idx,
  input  logic          din,
  output logic [W-2:0]  data,
  output logic          parity
);

  // Store the payload bit at idx and fold every loaded bit into parity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data   <= '0;
      parity <= 1'b0;
    end else if (clr) begin
      data   <= '0;
      parity <= 1'b0;
    end else if (load) begin
      parity <= parity ^ din;
      for (int i = 0; i < int'(W) - 1; i++) begin
        if (idx == IW'(i)) data[i] <= din;
      end
    end
  end

endmodule

// File: rtl/c_frag_cfg_loader.sv
// Serial config writer for one C_FRAG cell: shift in a 15-bit frame,
// parity-check it, then commit all routing inputs and the mode flag at once.
module c_frag_cfg_loader
  import c_frag_cfg_loader_pkg::*;
#(
  parameter bit PARITY_ODD = 1'b0,
  parameter bit ERR_STICKY = 1'b1
) (
  input  logic QCK,
  input  logic QRT,
  input  logic CFG_START,
  input  logic CFG_DIN,
  input  logic CFG_VLD,
  output logic CFG_RDY,
  output logic CFG_DONE,
  output logic CFG_ERR,
  output logic TBS,
  output logic TAB,
  output logic TSL,
  output logic TA1,
  output logic TA2,
  output logic TB1,
  output logic TB2,
  output logic BAB,
  output logic BSL,
  output logic BA1,
  output logic BA2,
  output logic BB1,
  output logic BB2,
  output logic MODE_SPLIT
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               clr_c, load_c, commit_c;
  logic [CFG_BITS-1:0] frame_data;
  logic               frame_par;
  cfg_t               cfg_q;
  logic               rdy_q, done_q, err_q;

  c_frag_cfg_loader_shift_reg #(
    .W  (FRAME_BITS),
    .IW (CNT_W)
  ) u_shift_reg (
    .clk    (QCK),
    .rst    (QRT),
    .clr    (clr_c),
    .load   (load_c),
    .idx    (cnt_q),
    .din    (CFG_DIN),
    .data   (frame_data),
    .parity (frame_par)
  );

  // Next-state and control decode; START wins over a coincident transfer.
  always_comb begin
    state_d  = state_q;
    clr_c    = 1'b0;
    load_c   = 1'b0;
    commit_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (CFG_START) begin
          state_d = ST_SHIFT;
          clr_c   = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (CFG_START) begin
          clr_c = 1'b1;
        end else if (CFG_VLD) begin
          load_c = 1'b1;
          if (cnt_q == CNT_W'(BIT_PARITY)) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (parity_pass(frame_par, PARITY_ODD)) begin
          commit_c = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_ERROR;
        end
      end
      ST_ERROR: begin
        if (CFG_START) begin
          state_d = ST_SHIFT;
          clr_c   = 1'b1;
        end else if (!ERR_STICKY) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, bit counter, commit register and registered status flags.
  always_ff @(posedge QCK or posedge QRT) begin
    if (QRT) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cfg_q   <= '0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (clr_c) begin
        cnt_q <= '0;
      end else if (load_c && state_d == ST_SHIFT) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (commit_c) cfg_q <= cfg_t'(frame_data);
      rdy_q  <= (state_d == ST_SHIFT);
      done_q <= commit_c;
      err_q  <= (state_d == ST_ERROR);
    end
  end

  assign CFG_RDY    = rdy_q;
  assign CFG_DONE   = done_q;
  assign CFG_ERR    = err_q;
  assign TBS        = cfg_q.tbs;
  assign TAB        = cfg_q.tab;
  assign TSL        = cfg_q.tsl;
  assign TA1        = cfg_q.ta1;
  assign TA2        = cfg_q.ta2;
  assign TB1        = cfg_q.tb1;
  assign TB2        = cfg_q.tb2;
  assign BAB        = cfg_q.bab;
  assign BSL        = cfg_q.bsl;
  assign BA1        = cfg_q.ba1;
  assign BA2        = cfg_q.ba2;
  assign BB1        = cfg_q.bb1;
  assign BB2        = cfg_q.bb2;
  assign MODE_SPLIT = cfg_q.mode_split;

endmodule

// File: tb/tb_c_frag_cfg_loader.sv
// Bench for c_frag_cfg_loader: dut0 = even parity / sticky error,
// dut1 = odd parity / one-cycle error. Expected outputs come from a frame-level model.
module tb_c_frag_cfg_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  start = '0;
  logic [1:0]  din = '0;
  logic [1:0]  vld = '0;
  wire  [1:0]  rdy, done, err;
  wire  [13:0] out0, out1;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt [2];
  logic [13:0] exp_cfg [2];

  always #5 clk = ~clk;

  // Count DONE pulses seen at each rising edge.
  always @(posedge clk) begin
    if (done[0] === 1'b1) done_cnt[0] <= done_cnt[0] + 1;
    if (done[1] === 1'b1) done_cnt[1] <= done_cnt[1] + 1;
  end

  c_frag_cfg_loader #(.PARITY_ODD(1'b0), .ERR_STICKY(1'b1)) dut0 (
    .QCK(clk), .QRT(rst), .CFG_START(start[0]), .CFG_DIN(din[0]), .CFG_VLD(vld[0]),
    .CFG_RDY(rdy[0]), .CFG_DONE(done[0]), .CFG_ERR(err[0]),
    .TBS(out0[0]), .TAB(out0[1]), .TSL(out0[2]), .TA1(out0[3]), .TA2(out0[4]),
    .TB1(out0[5]), .TB2(out0[6]), .BAB(out0[7]), .BSL(out0[8]), .BA1(out0[9]),
    .BA2(out0[10]), .BB1(out0[11]), .BB2(out0[12]), .MODE_SPLIT(out0[13])
  );

  c_frag_cfg_loader #(.PARITY_ODD(1'b1), .ERR_STICKY(1'b0)) dut1 (
    .QCK(clk), .QRT(rst), .CFG_START(start[1]), .CFG_DIN(din[1]), .CFG_VLD(vld[1]),
    .CFG_RDY(rdy[1]), .CFG_DONE(done[1]), .CFG_ERR(err[1]),
    .TBS(out1[0]), .TAB(out1[1]), .TSL(out1[2]), .TA1(out1[3]), .TA2(out1[4]),
    .TB1(out1[5]), .TB2(out1[6]), .BAB(out1[7]), .BSL(out1[8]), .BA1(out1[9]),
    .BA2(out1[10]), .BB1(out1[11]), .BB2(out1[12]), .MODE_SPLIT(out1[13])
  );

  function automatic logic odd_of(input int s);
    return (s == 1);
  endfunction

  function automatic logic sticky_of(input int s);
    return (s == 0);
  endfunction

  function automatic logic [13:0] outs(input int s);
    return (s == 0) ? out0 : out1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Start a frame and push nbits random bits without finishing it.
  task automatic send_partial(input int s, input int nbits);
    start[s] = 1'b1; vld[s] = 1'b0; tick();
    start[s] = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      vld[s] = 1'b1; din[s] = 1'($urandom_range(0, 1)); tick();
    end
    vld[s] = 1'b0;
  endtask

  // Full frame: mode 0 = VLD always high, 1 = VLD every other cycle, 2 = random VLD.
  task automatic send_frame(input int s, input logic [14:0] f, input int mode, input bit start_with_vld);
    int n;
    int cyc;
    logic v;
    logic ok;
    logic [13:0] prev;
    start[s] = 1'b1; vld[s] = start_with_vld; din[s] = 1'b1; tick();
    start[s] = 1'b0; vld[s] = 1'b0;
    chk("start_rdy", 32'(rdy[s]), 32'd1);
    chk("start_err", 32'(err[s]), 32'd0);
    prev = exp_cfg[s];
    n = 0;
    cyc = 0;
    while (n < 15 && cyc < 200) begin
      if (mode == 0) v = 1'b1;
      else if (mode == 1) v = 1'(cyc % 2);
      else v = 1'($urandom_range(0, 1));
      vld[s] = v;
      din[s] = v ? f[n] : 1'($urandom_range(0, 1));
      chk("shift_rdy", 32'(rdy[s]), 32'd1);
      tick();
      cyc++;
      if (v) n++;
    end
    if (cyc >= 200) chk("xfer_timeout", 32'(n), 32'd15);
    vld[s] = 1'b0;
    chk("check_rdy", 32'(rdy[s]), 32'd0);
    chk("check_done", 32'(done[s]), 32'd0);
    chk("check_hold", 32'(outs(s)), 32'(prev));
    tick();
    ok = ((^f) == odd_of(s));
    if (ok) exp_cfg[s] = f[13:0];
    chk("commit_done", 32'(done[s]), 32'(ok));
    chk("commit_err", 32'(err[s]), 32'(!ok));
    chk("commit_outs", 32'(outs(s)), 32'(exp_cfg[s]));
    chk("commit_rdy", 32'(rdy[s]), 32'd0);
    tick();
    chk("after_done", 32'(done[s]), 32'd0);
    chk("after_err", 32'(err[s]), 32'(!ok && sticky_of(s)));
    chk("after_rdy", 32'(rdy[s]), 32'd0);
    chk("after_outs", 32'(outs(s)), 32'(exp_cfg[s]));
  endtask

  initial begin
    int dc;
    logic [14:0] f;
    exp_cfg[0] = '0;
    exp_cfg[1] = '0;

    // Reset values
    tick(); tick();
    chk("rst_outs0", 32'(out0), 32'd0);
    chk("rst_outs1", 32'(out1), 32'd0);
    chk("rst_flags0", 32'({rdy[0], done[0], err[0]}), 32'd0);
    chk("rst_flags1", 32'({rdy[1], done[1], err[1]}), 32'd0);
    rst = 1'b0;
    tick();

    // Good frame: TBS, TA1, BB2, MODE_SPLIT set, even parity
    send_frame(0, 15'h3009, 0, 1'b0);

    // Bad parity: outputs hold, RDY stays low until next START
    send_frame(0, 15'h7009, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      vld[0] = 1'b1; din[0] = 1'b1; tick();
      chk("err_hold_rdy", 32'(rdy[0]), 32'd0);
      chk("err_hold_err", 32'(err[0]), 32'd1);
      chk("err_hold_outs", 32'(out0), 32'(exp_cfg[0]));
    end
    vld[0] = 1'b0;

    // Back-pressure with alternating 1/0 frame
    send_frame(0, 15'h5555, 1, 1'b0);

    // Abort: 7 bits, restart coinciding with a valid bit, then a full frame
    dc = done_cnt[0];
    send_partial(0, 7);
    send_frame(0, 15'h2A0F ^ 15'h0000, 0, 1'b1);
    chk("abort_done_cnt", 32'(done_cnt[0] - dc), 32'(((^15'h2A0F) == 1'b0) ? 1 : 0));

    // Async reset mid-SHIFT after an all-ones commit
    send_frame(0, 15'h3FFF, 0, 1'b0);
    dc = done_cnt[0];
    send_partial(0, 5);
    #2 rst = 1'b1;
    #1;
    chk("arst_outs0", 32'(out0), 32'd0);
    chk("arst_outs1", 32'(out1), 32'd0);
    chk("arst_rdy", 32'(rdy[0]), 32'd0);
    exp_cfg[0] = '0;
    exp_cfg[1] = '0;
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("arst_no_done", 32'(done_cnt[0] - dc), 32'd0);
    send_frame(0, 15'h1234 ^ 15'h0000, 2, 1'b0);

    // Odd parity, non-sticky error
    send_frame(1, 15'h3009, 0, 1'b0);
    tick();
    chk("ns_idle_err", 32'(err[1]), 32'd0);
    send_frame(1, 15'h7009, 0, 1'b0);

    // Randomised frames on both instances, mostly good parity
    for (int k = 0; k < 10; k++) begin
      int s;
      s = k % 2;
      f = 15'($urandom);
      if ($urandom_range(0, 3) != 0) f[14] = (^f[13:0]) ^ odd_of(s);
      dc = done_cnt[s];
      send_frame(s, f, 2, 1'($urandom_range(0, 1)));
      tick();
      chk("rand_done_cnt", 32'(done_cnt[s] - dc), 32'(((^f) == odd_of(s)) ? 1 : 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
